// File: rtl/batch_pulse_counter.sv
// batch_pulse_counter: N_CH pulse counters closed by batch_done; `BPC_SATURATE_EN selects saturate vs wrap at max.
// Latency: latched outputs and valid appear one cycle after batch_done; no backpressure, later strobes overwrite.
module batch_pulse_counter #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 16,
    parameter int SEQ_W     = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         raw_pulses,
    input  logic                    count_en,
    input  logic                    batch_done,
    output logic [N_CH*CNT_W-1:0]   reg_count,
    output logic [N_CH-1:0]         ovf,
    output logic [SEQ_W-1:0]        batch_seq,
    output logic                    valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0][CNT_W-1:0] q;
    logic [N_CH-1:0][CNT_W-1:0] q_nxt;
    logic [N_CH-1:0][CNT_W-1:0] cnt_lat;
    logic [N_CH-1:0]            of;
    logic [N_CH-1:0]            of_nxt;
    logic [N_CH-1:0]            prev;
    logic [N_CH-1:0]            evt;

    always_comb begin
        if (EDGE_MODE != 0) begin
            evt = raw_pulses & ~prev & {N_CH{count_en}};
        end else begin
            evt = raw_pulses & {N_CH{count_en}};
        end
    end

    // An event coincident with batch_done opens the new batch at 1.
    always_comb begin
        q_nxt  = q;
        of_nxt = of;
        for (int i = 0; i < N_CH; i++) begin
            if (batch_done) begin
                q_nxt[i]  = evt[i] ? CNT_W'(1) : '0;
                of_nxt[i] = 1'b0;
            end else if (evt[i]) begin
                if (q[i] != CNT_MAX) begin
                    q_nxt[i] = q[i] + CNT_W'(1);
                end else begin
`ifdef BPC_SATURATE_EN
                    q_nxt[i] = CNT_MAX;
`else
                    q_nxt[i] = '0;
`endif
                    of_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            of        <= '0;
            prev      <= '0;
            cnt_lat   <= '0;
            ovf       <= '0;
            batch_seq <= '0;
            valid     <= 1'b0;
        end else begin
            q     <= q_nxt;
            of    <= of_nxt;
            prev  <= raw_pulses;
            valid <= batch_done;
            if (batch_done) begin
                cnt_lat   <= q;
                ovf       <= of;
                batch_seq <= batch_seq + SEQ_W'(1);
            end
        end
    end

    assign reg_count = cnt_lat;

endmodule

// File: tb/tb_batch_pulse_counter.sv
// Bench for batch_pulse_counter: level- and edge-mode instances driven together, checked against a batch-total model.
module tb_batch_pulse_counter;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int SEQ_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       raw_pulses;
    logic                  count_en;
    logic                  batch_done;
    logic [N_CH*CNT_W-1:0] reg_count0, reg_count1;
    logic [N_CH-1:0]       ovf0, ovf1;
    logic [SEQ_W-1:0]      seq0, seq1;
    logic                  valid0, valid1;

    always #5 clk = ~clk;

    batch_pulse_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .SEQ_W(SEQ_W), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .raw_pulses(raw_pulses), .count_en(count_en),
        .batch_done(batch_done), .reg_count(reg_count0), .ovf(ovf0),
        .batch_seq(seq0), .valid(valid0));

    batch_pulse_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .SEQ_W(SEQ_W), .EDGE_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .raw_pulses(raw_pulses), .count_en(count_en),
        .batch_done(batch_done), .reg_count(reg_count1), .ovf(ovf1),
        .batch_seq(seq1), .valid(valid1));

    int n_cmp = 0;
    int n_err = 0;

    // Model: unbounded event totals per batch, folded to the counter width only at close.
    int             tot0 [N_CH];
    int             tot1 [N_CH];
    logic [N_CH-1:0] m_prev;
    logic [7:0]     e_cnt0 [N_CH];
    logic [7:0]     e_cnt1 [N_CH];
    logic [N_CH-1:0] e_ovf0, e_ovf1;
    logic [7:0]     e_seq;
    logic           e_vld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fold(input int t);
`ifdef BPC_SATURATE_EN
        return (t > 255) ? 8'd255 : t[7:0];
`else
        return t[7:0];
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            tot0[i] = 0; tot1[i] = 0; e_cnt0[i] = 0; e_cnt1[i] = 0;
        end
        m_prev = '0; e_ovf0 = '0; e_ovf1 = '0; e_seq = '0; e_vld = 1'b0;
    endtask

    task automatic model_edge();
        int ev0, ev1;
        for (int i = 0; i < N_CH; i++) begin
            ev0 = (raw_pulses[i] && count_en) ? 1 : 0;
            ev1 = (raw_pulses[i] && !m_prev[i] && count_en) ? 1 : 0;
            if (batch_done) begin
                e_cnt0[i] = fold(tot0[i]);
                e_cnt1[i] = fold(tot1[i]);
                e_ovf0[i] = (tot0[i] > 255);
                e_ovf1[i] = (tot1[i] > 255);
                tot0[i] = ev0;
                tot1[i] = ev1;
            end else begin
                tot0[i] += ev0;
                tot1[i] += ev1;
            end
        end
        if (batch_done) e_seq = e_seq + 8'd1;
        e_vld  = batch_done;
        m_prev = raw_pulses;
    endtask

    task automatic check_all();
        for (int i = 0; i < N_CH; i++) begin
            check($sformatf("lvl_cnt%0d", i), 32'(reg_count0[i*CNT_W +: CNT_W]), 32'(e_cnt0[i]));
            check($sformatf("edg_cnt%0d", i), 32'(reg_count1[i*CNT_W +: CNT_W]), 32'(e_cnt1[i]));
        end
        check("lvl_ovf", 32'(ovf0), 32'(e_ovf0));
        check("edg_ovf", 32'(ovf1), 32'(e_ovf1));
        check("lvl_seq", 32'(seq0), 32'(e_seq));
        check("edg_seq", 32'(seq1), 32'(e_seq));
        check("lvl_valid", 32'(valid0), 32'(e_vld));
        check("edg_valid", 32'(valid1), 32'(e_vld));
    endtask

    task automatic cyc(input logic [N_CH-1:0] r, input logic e, input logic b);
        @(negedge clk);
        raw_pulses = r; count_en = e; batch_done = b;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    initial begin
        rst_n = 1'b0; raw_pulses = '0; count_en = 1'b0; batch_done = 1'b0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1 check_all();
        end
        rst_n = 1'b1;

        // Level count of a steady pattern.
        repeat (10) cyc(4'b0101, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b1);
        check("t1_ch0", 32'(reg_count0[7:0]), 32'd10);
        check("t1_ch2", 32'(reg_count0[23:16]), 32'd10);
        check("t1_ch1", 32'(reg_count0[15:8]), 32'd0);
        check("t1_seq", 32'(seq0), 32'd1);
        check("t1_valid", 32'(valid0), 32'd1);

        // Edge mode: toggling ch0, ch1 held high.
        for (int k = 0; k < 20; k++) cyc({2'b00, 1'b1, (k % 2 == 0)}, 1'b1, 1'b0);
        cyc(4'b0010, 1'b1, 1'b1);
        check("t2_edg_ch0", 32'(reg_count1[7:0]), 32'd10);
        check("t2_edg_ch1", 32'(reg_count1[15:8]), 32'd1);

        // Pulse coincident with batch_done belongs to the next batch.
        repeat (5) begin
            cyc(4'b1000, 1'b1, 1'b0);
            cyc(4'b0000, 1'b1, 1'b0);
        end
        cyc(4'b1000, 1'b1, 1'b1);
        check("t3_lvl_ch3", 32'(reg_count0[31:24]), 32'd5);
        check("t3_edg_ch3", 32'(reg_count1[31:24]), 32'd5);
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b1);
        check("t3_next_ch3", 32'(reg_count0[31:24]), 32'd2);

        // Overflow with 300 pulses on ch1.
        repeat (300) begin
            cyc(4'b0010, 1'b1, 1'b0);
            cyc(4'b0000, 1'b1, 1'b0);
        end
        cyc(4'b0000, 1'b1, 1'b1);
`ifdef BPC_SATURATE_EN
        check("t4_ch1", 32'(reg_count0[15:8]), 32'd255);
`else
        check("t4_ch1", 32'(reg_count0[15:8]), 32'd44);
`endif
        check("t4_ovf1", 32'(ovf0[1]), 32'd1);
        repeat (3) cyc(4'b0010, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b1);
        check("t4_next_ovf1", 32'(ovf0[1]), 32'd0);

        // count_en low suppresses counting but not batch handling.
        repeat (8) cyc(4'b1111, 1'b0, 1'b0);
        cyc(4'b1111, 1'b0, 1'b1);
        check("t5_cnt", 32'(reg_count0), 32'd0);
        check("t5_valid", 32'(valid0), 32'd1);

        // Back-to-back strobes.
        cyc(4'b0001, 1'b1, 1'b1);
        cyc(4'b0001, 1'b1, 1'b1);
        check("t6_b2b_ch0", 32'(reg_count0[7:0]), 32'd1);

        // Randomized traffic.
        repeat (2000) cyc(N_CH'($urandom), ($urandom_range(7) != 0), ($urandom_range(15) == 0));

        // Reset mid-batch discards the live counts.
        cyc(4'b0000, 1'b1, 1'b1);
        repeat (7) begin
            cyc(4'b0001, 1'b1, 1'b0);
            cyc(4'b0000, 1'b1, 1'b0);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        repeat (3) begin
            @(posedge clk);
            #1 check_all();
        end
        rst_n = 1'b1;
        cyc(4'b0000, 1'b1, 1'b1);
        check("t7_ch0", 32'(reg_count0[7:0]), 32'd0);
        check("t7_seq", 32'(seq0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
